// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// select codes, opcode/cmd fields and the data-processing ALU decode.
package multicycle_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_FETCH  = 4'd0;
   localparam state_t S_DECODE = 4'd1;
   localparam state_t S_MEMADR = 4'd2;
   localparam state_t S_MEMRD  = 4'd3;
   localparam state_t S_MEMWB  = 4'd4;
   localparam state_t S_MEMWR  = 4'd5;
   localparam state_t S_EXECR  = 4'd6;
   localparam state_t S_EXECI  = 4'd7;
   localparam state_t S_ALUWB  = 4'd8;
   localparam state_t S_BRANCH = 4'd9;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_CMP = 4'b1010;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   typedef struct packed {
      logic       nowrite;
      logic [1:0] alu_ctl;
   } alu_dec_t;

   // Unknown cmds fall back to a harmless add with the register write blocked.
   function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
      alu_dec_t d;
      d.nowrite = 1'b0;
      d.alu_ctl = ALU_ADD;
      case (cmd)
         CMD_ADD: d.alu_ctl = ALU_ADD;
         CMD_SUB: d.alu_ctl = ALU_SUB;
         CMD_AND: d.alu_ctl = ALU_AND;
         CMD_ORR: d.alu_ctl = ALU_ORR;
         CMD_CMP: begin
            d.alu_ctl = ALU_SUB;
            d.nowrite = 1'b1;
         end
         default: d.nowrite = 1'b1;
      endcase
      return d;
   endfunction

   function automatic logic updates_cv(input logic [3:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields and flags in, datapath selects and enables out.
interface multicycle_controller_if;
   import multicycle_pkg::*;

   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;

   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUControl;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   state_t     State;

   // master: the controller; slave: the datapath it steers
   modport master (
      input  Cond, Op, Funct, Rd, ALUFlags,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, State
   );

   modport slave (
      output Cond, Op, Funct, Rd, ALUFlags,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, State
   );

endinterface

// File: rtl/cond_check.sv
// ARM condition-code evaluation against the registered NZCV flags.
module cond_check (
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n, z, c, v, ge;

   assign {n, z, c, v} = Flags;
   assign ge = (n == v);

   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         4'b0000: CondEx = z;
         4'b0001: CondEx = ~z;
         4'b0010: CondEx = c;
         4'b0011: CondEx = ~c;
         4'b0100: CondEx = n;
         4'b0101: CondEx = ~n;
         4'b0110: CondEx = v;
         4'b0111: CondEx = ~v;
         4'b1000: CondEx = c & ~z;
         4'b1001: CondEx = ~c | z;
         4'b1010: CondEx = ge;
         4'b1011: CondEx = ~ge;
         4'b1100: CondEx = ~z & ge;
         4'b1101: CondEx = z | ~ge;
         4'b1110: CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: sequences fetch/decode/execute/writeback, owns the
// NZCV flags and the per-instruction condition-pass bit.
module multicycle_controller
   import multicycle_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   multicycle_controller_if.master bus
);

   state_t     state_q, state_d;
   logic [3:0] flags_q, flags_d;
   logic       condex_q, condex_d;
   logic       cond_ex;
   alu_dec_t   dec;
   logic       nowrite, rd_pc, wb_pc, wb_reg, in_exec;

   logic       pc_wr, adr, mem_wr, ir_wr, reg_wr, src_a;
   logic [1:0] res_src, src_b, alu_ctl;

   cond_check u_cond (
      .Cond   (bus.Cond),
      .Flags  (flags_q),
      .CondEx (cond_ex)
   );

   assign dec     = alu_decode(bus.Funct[4:1]);
   assign nowrite = (bus.Op == OP_DP) & dec.nowrite;
   assign rd_pc   = (bus.Rd == 4'd15);
   assign wb_pc   = condex_q & rd_pc;
   assign wb_reg  = condex_q & ~nowrite & ~rd_pc;
   assign in_exec = (state_q == S_EXECR) || (state_q == S_EXECI);

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (bus.Op)
               OP_MEM:  state_d = S_MEMADR;
               OP_DP:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
               OP_BR:   state_d = S_BRANCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXECR,
         S_EXECI:  state_d = S_ALUWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // condex_q is frozen after DECODE, so this instruction's own flag update
   // cannot change whether its writeback happens.
   always_comb begin
      condex_d = (state_q == S_DECODE) ? cond_ex : condex_q;
      flags_d  = flags_q;
      if (in_exec && condex_q && bus.Funct[0]) begin
         flags_d[3:2] = bus.ALUFlags[3:2];
         if (updates_cv(bus.Funct[4:1])) flags_d[1:0] = bus.ALUFlags[1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_FETCH;
         flags_q  <= 4'b0000;
         condex_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         flags_q  <= flags_d;
         condex_q <= condex_d;
      end
   end

   always_comb begin
      pc_wr   = 1'b0;
      adr     = 1'b0;
      mem_wr  = 1'b0;
      ir_wr   = 1'b0;
      reg_wr  = 1'b0;
      res_src = RES_ALUOUT;
      src_a   = 1'b0;
      src_b   = SRCB_RD2;
      alu_ctl = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            ir_wr   = 1'b1;
            src_a   = 1'b1;
            src_b   = SRCB_FOUR;
            res_src = RES_ALURESULT;
            pc_wr   = 1'b1;
         end
         // Second PC+4 gives PC+8 for instructions that read R15.
         S_DECODE: begin
            src_a   = 1'b1;
            src_b   = SRCB_FOUR;
            res_src = RES_ALURESULT;
         end
         S_MEMADR: src_b = SRCB_IMM;
         S_MEMRD:  adr = 1'b1;
         S_MEMWR: begin
            adr    = 1'b1;
            mem_wr = condex_q;
         end
         S_MEMWB: begin
            res_src = RES_DATA;
            pc_wr   = wb_pc;
            reg_wr  = wb_reg;
         end
         S_EXECR:  alu_ctl = dec.alu_ctl;
         S_EXECI: begin
            src_b   = SRCB_IMM;
            alu_ctl = dec.alu_ctl;
         end
         S_ALUWB: begin
            pc_wr  = wb_pc;
            reg_wr = wb_reg;
         end
         S_BRANCH: begin
            src_b   = SRCB_IMM;
            res_src = RES_ALURESULT;
            pc_wr   = condex_q;
         end
         default: ;
      endcase
   end

   // Architectural enables are blocked for as long as reset is held.
   assign bus.PCWrite    = pc_wr & reset;
   assign bus.MemWrite   = mem_wr & reset;
   assign bus.IRWrite    = ir_wr & reset;
   assign bus.RegWrite   = reg_wr & reset;
   assign bus.AdrSrc     = adr;
   assign bus.ResultSrc  = res_src;
   assign bus.ALUSrcA    = src_a;
   assign bus.ALUSrcB    = src_b;
   assign bus.ALUControl = alu_ctl;
   assign bus.ImmSrc     = bus.Op;
   assign bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};
   assign bus.State      = state_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle ARM-subset datapath: one shared memory, instruction register, ALU reused for PC increment.
- Sequences each instruction through fetch/decode/execute/writeback states and drives all datapath selects and write enables.
- Holds the NZCV flags register and evaluates ARM condition codes.
- Sits beside the datapath in the processor top; consumes instruction fields and ALUFlags.

Parameters:
- none (ISA subset is fixed: ADD, SUB, AND, ORR, CMP, LDR, STR, B)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUResult register
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  1  ALU A select: 0 = RD1, 1 = PC
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ExtImm, 10 = constant 4
- ALUControl  out  2  00 = add, 01 = sub, 10 = and, 11 = orr
- ImmSrc  out  2  equals Op
- RegSrc  out  2  RegSrc[0] = (Op == 10); RegSrc[1] = (Op == 01)
- State  out  4  current state encoding, for debug

Behaviour:
- Reset low:
  - state is FETCH; Flags = 0000; condex_q = 0.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced 0 while reset is low.
- Moore outputs: every output is combinational from state plus registered data only. Exceptions: ImmSrc and RegSrc, which decode Op directly.
- States, their encodings and transitions:
  - FETCH (0) -> DECODE.
  - DECODE (1):
    - Op = 01 -> MEMADR
    - Op = 00 with Funct[5] = 0 -> EXECR
    - Op = 00 with Funct[5] = 1 -> EXECI
    - Op = 10 -> BRANCH
    - Op = 11 -> FETCH (undefined instruction, treated as NOP)
  - MEMADR (2): Funct[0] = 1 -> MEMRD, else MEMWR.
  - MEMRD (3) -> MEMWB (4) -> FETCH.
  - MEMWR (5) -> FETCH.
  - EXECR (6) and EXECI (7) -> ALUWB (8) -> FETCH.
  - BRANCH (9) -> FETCH.
  - Encodings 10-15 -> FETCH.
- Per-state outputs (unlisted outputs are 0):
  - FETCH: AdrSrc = 0, IRWrite = 1, ALUSrcA = 1, ALUSrcB = 10, add, ResultSrc = 10, PCWrite = 1.
  - DECODE: ALUSrcA = 1, ALUSrcB = 10, add, ResultSrc = 10 (forms PC+8 for R15 reads).
  - MEMADR: ALUSrcA = 0, ALUSrcB = 01, add.
  - MEMRD: AdrSrc = 1.
  - MEMWR: AdrSrc = 1, MemWrite = condex_q.
  - MEMWB: ResultSrc = 01; write enable per the writeback rule below.
  - EXECR: ALUSrcA = 0, ALUSrcB = 00, ALU op decoded.
  - EXECI: ALUSrcA = 0, ALUSrcB = 01, ALU op decoded.
  - ALUWB: ResultSrc = 00; write enable per the writeback rule below.
  - BRANCH: ALUSrcA = 0, ALUSrcB = 01, add, ResultSrc = 10, PCWrite = condex_q.
- ALU decode in EXECR/EXECI, on cmd = Funct[4:1]:
  - 0100 ADD -> 00
  - 0010 SUB -> 01
  - 0000 AND -> 10
  - 1100 ORR -> 11
  - 1010 CMP -> 01, with NoWrite = 1
  - Any other cmd -> 00, with NoWrite = 1
- Writeback rule (ALUWB, MEMWB):
  - Rd == 15: PCWrite = condex_q and RegWrite = 0.
  - Otherwise: RegWrite = condex_q & ~NoWrite.
- Condition check (combinational on the Flags register), for Cond 0000-1110:
  - EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL: standard ARM meanings.
  - 1111 -> not executed.
- condex_q is loaded on the clock edge leaving DECODE. It is held for the rest of the instruction, so a flag update in EXEC cannot alter that instruction's own writeback.
- Flag update happens on the clock edge leaving EXECR/EXECI when condex_q = 1 and S = Funct[0] = 1:
  - N,Z always load.
  - C,V load only for ADD, SUB and CMP.
  - AND and ORR keep the old C,V.
- Reset asserted mid-instruction: immediate return to FETCH, flags cleared, no partial write completes after the asserting edge.
- Latency in cycles, fetch included: LDR 5; STR 4; data-processing 4; B 3; undefined or condition-failed instructions consume their full path with enables suppressed.

Decomposition:
- Package multicycle_pkg holds:
  - the state enum (4-bit, encodings above);
  - ALUControl constants;
  - Op codes (DP = 00, MEM = 01, BR = 10);
  - cmd codes (ADD, SUB, AND, ORR, CMP);
  - ResultSrc and ALUSrcB select constants.
- Sub-module cond_check:
  - inputs: Cond, Flags;
  - output: CondEx;
  - purely combinational; instantiated once.

Test Plan:
- Reset held low 3 cycles, then released -> State = 0, PCWrite = IRWrite = 0 during reset; first cycle after release PCWrite = 1, IRWrite = 1, ALUSrcB = 10.
- ADDS R1,R2,R3 (Cond = 1110, Op = 00, Funct = 001001), ALUFlags = 0110 -> states 0, 1, 6, 8; ALUControl = 00 in EXECR; RegWrite = 1 in ALUWB; Flags = 0110 afterwards.
- LDR (Op = 01, Funct[0] = 1, Rd = 15) -> states 0, 1, 2, 3, 4; AdrSrc = 1 in MEMRD; in MEMWB PCWrite = 1, RegWrite = 0, ResultSrc = 01.
- STR with Cond = 0000 (EQ) and Flags Z = 0 -> states 0, 1, 2, 5; MemWrite stays 0.
- CMP sets Z (ALUFlags = 0100), then BEQ (Op = 10, Cond = 0000) -> CMP gives RegWrite = 0 in ALUWB; BEQ traverses 0, 1, 9 with PCWrite = 1 in BRANCH. Repeat with ALUFlags = 0000 -> PCWrite = 0 in BRANCH.
- Reset pulsed low during MEMWR -> MemWrite drops at once, State = 0, Flags = 0000.
